// File: rtl/reg_file.sv
// 32 x 64-bit register file: two combinational read ports, one write port.
// Register ZERO_REG is hardwired to zero and has no storage.
module reg_file #(
    parameter int DATA_W   = 64,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 31
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we3,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    input  logic [ADDR_W-1:0] wa3,
    input  logic [DATA_W-1:0] wd3,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2
);

    localparam int NREG = 2 ** ADDR_W;

    logic [DATA_W-1:0] q [NREG];

    for (genvar i = 0; i < NREG; i++) begin : g_reg
        if (i == ZERO_REG) begin : g_zero
            assign q[i] = '0;
        end else begin : g_store
            // Power-up value matches the reset value: the register's index.
            logic [DATA_W-1:0] r = DATA_W'(i);

            // Reset reloads the index value and wins over a same-edge write.
            always_ff @(posedge clk) begin
                if (reset) begin
                    r <= DATA_W'(i);
                end else if (we3 && (wa3 == ADDR_W'(i))) begin
                    r <= wd3;
                end
            end

            assign q[i] = r;
        end
    end

    // Reads bypass nothing: a same-cycle write shows up after the edge.
    assign rd1 = q[ra1];
    assign rd2 = q[ra2];

endmodule

// File: tb/tb_reg_file.sv
// Randomized scoreboard bench for reg_file.
// Expected reads come from a plain array model of the register contents.
module tb_reg_file;

    localparam int DW = 64;
    localparam int AW = 5;

    typedef struct packed {
        logic [AW-1:0] a1;
        logic [AW-1:0] a2;
        logic [DW-1:0] e1;
        logic [DW-1:0] e2;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          we3 = 1'b0;
    logic [AW-1:0] ra1 = '0;
    logic [AW-1:0] ra2 = '0;
    logic [AW-1:0] wa3 = '0;
    logic [DW-1:0] wd3 = '0;
    logic [DW-1:0] rd1;
    logic [DW-1:0] rd2;

    int   n_checks = 0;
    int   n_fail = 0;
    bit   done = 1'b0;
    exp_t sb [$];

    logic [DW-1:0] m [31];

    reg_file dut (
        .clk   (clk),
        .reset (reset),
        .we3   (we3),
        .ra1   (ra1),
        .ra2   (ra2),
        .wa3   (wa3),
        .wd3   (wd3),
        .rd1   (rd1),
        .rd2   (rd2)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] model_rd(input logic [AW-1:0] a);
        if (a == 5'd31) return '0;
        return m[a];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 31; i++) m[i] = DW'(i);
    endtask

    // One clock: drive inputs, predict reads, then apply the edge to the model.
    task automatic cyc(input logic r, input logic we,
                       input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                       input logic [AW-1:0] a1, input logic [AW-1:0] a2);
        exp_t e;
        @(negedge clk);
        reset = r;
        we3 = we;
        wa3 = wa;
        wd3 = wd;
        ra1 = a1;
        ra2 = a2;
        e.a1 = a1;
        e.a2 = a2;
        e.e1 = model_rd(a1);
        e.e2 = model_rd(a2);
        sb.push_back(e);
        @(posedge clk);
        if (r) model_reset();
        else if (we && wa != 5'd31) m[wa] = wd;
    endtask

    // Monitor: sample reads mid-low-phase and compare with the oldest prediction.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                n_checks++;
                if (rd1 !== e.e1) begin
                    n_fail++;
                    $display("FAIL rd1 ra1=%0d got=%h want=%h", e.a1, rd1, e.e1);
                end
                n_checks++;
                if (rd2 !== e.e2) begin
                    n_fail++;
                    $display("FAIL rd2 ra2=%0d got=%h want=%h", e.a2, rd2, e.e2);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        model_reset();

        // Power-up contents, no reset applied yet.
        for (int i = 0; i < 32; i++)
            cyc(1'b0, 1'b0, 5'd0, '0, AW'(i), AW'(i));

        // Write to x0; rd2 watches an untouched register.
        cyc(1'b0, 1'b1, 5'd0, 64'd255, 5'd0, 5'd25);
        cyc(1'b0, 1'b1, 5'd0, 64'd255, 5'd0, 5'd25);
        cyc(1'b0, 1'b0, 5'd0, 64'd0, 5'd0, 5'd25);

        // Writes to XZR are dropped.
        cyc(1'b0, 1'b1, 5'd31, 64'hC0C0, 5'd31, 5'd31);
        cyc(1'b0, 1'b1, 5'd31, 64'hC4C4, 5'd31, 5'd31);
        cyc(1'b0, 1'b0, 5'd31, 64'd0, 5'd31, 5'd30);

        // Write enable low.
        for (int i = 0; i < 4; i++)
            cyc(1'b0, 1'b0, 5'd5, 64'hDEAD, 5'd5, 5'd5);

        // Reset beats a same-edge write.
        cyc(1'b0, 1'b1, 5'd7, 64'h1234, 5'd7, 5'd3);
        cyc(1'b1, 1'b1, 5'd3, 64'hFF, 5'd7, 5'd3);
        cyc(1'b0, 1'b0, 5'd0, 64'd0, 5'd7, 5'd3);
        cyc(1'b0, 1'b0, 5'd0, 64'd0, 5'd0, 5'd31);

        // Read during write returns the old value, new one next cycle.
        cyc(1'b0, 1'b1, 5'd10, 64'hABCD, 5'd10, 5'd10);
        cyc(1'b0, 1'b0, 5'd10, 64'd0, 5'd10, 5'd10);

        // Random traffic with occasional resets.
        for (int i = 0; i < 500; i++) begin
            logic [AW-1:0] w;
            logic [AW-1:0] x;
            logic [AW-1:0] y;
            w = AW'($urandom_range(31));
            x = ($urandom_range(3) == 0) ? w : AW'($urandom_range(31));
            y = ($urandom_range(3) == 0) ? x : AW'($urandom_range(31));
            cyc(($urandom_range(39) == 0), ($urandom_range(2) != 0), w,
                {$urandom, $urandom}, x, y);
        end

        // Final sweep of every register.
        for (int i = 0; i < 32; i++)
            cyc(1'b0, 1'b0, 5'd0, '0, AW'(i), AW'(31 - i));

        @(negedge clk);
        we3 = 1'b0;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        #4;
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain left=%0d want=0", sb.size());
        end
        done = 1'b1;
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
